fifo_to_axis: RTL and testbench



---
 rtl/fifo_to_axis.sv | 104 ++++++++++
 tb/tb_fifo_to_axis.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_axis.sv
// Drains a one-cycle-latency FIFO read port into an AXI4-Stream master through a 3-entry skid buffer.
// Optional TLAST packetisation is built when FIFO_TO_AXIS_TLAST_EN is defined; otherwise TLAST is tied low.
module fifo_to_axis #(
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned PKT_LEN    = 16
) (
    input  logic                  ACLK,
    input  logic                  RST,
    output logic                  FIFO_RD_ENA,
    input  logic [FIFO_WIDTH-1:0] FIFO_RD_DATA,
    input  logic                  FIFO_RD_EMPTY,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic [FIFO_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST
);

    localparam int unsigned DEPTH    = 3;
    localparam int unsigned PTR_W    = 2;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned CREDIT_W = 3;

    if (FIFO_WIDTH < 1) begin : g_bad_width
        $error("fifo_to_axis: FIFO_WIDTH must be at least 1");
    end
    if (PKT_LEN < 1) begin : g_bad_pkt_len
        $error("fifo_to_axis: PKT_LEN must be at least 1");
    end

    logic [FIFO_WIDTH-1:0] buf_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  pending;
    logic                  credit_ok;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Words already buffered plus the one in flight must leave room for another read.
    assign credit_ok     = (CREDIT_W'(cnt) + CREDIT_W'(pending)) < CREDIT_W'(DEPTH);
    assign FIFO_RD_ENA   = !RST && !FIFO_RD_EMPTY && credit_ok;
    assign M_AXIS_TVALID = (cnt != '0);
    assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;

    always_comb begin
        M_AXIS_TDATA = buf_mem[0];
        case (rd_ptr)
            2'd0:    M_AXIS_TDATA = buf_mem[0];
            2'd1:    M_AXIS_TDATA = buf_mem[1];
            default: M_AXIS_TDATA = buf_mem[2];
        endcase
    end

    // Buffer storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (pending && (wr_ptr == PTR_W'(i))) begin
                buf_mem[i] <= FIFO_RD_DATA;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            pending <= FIFO_RD_ENA;
            if (pending) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            cnt <= cnt + CNT_W'(pending) - CNT_W'(pop);
        end
    end

`ifdef FIFO_TO_AXIS_TLAST_EN
    localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    logic [BEAT_W-1:0] beat;

    // Beat position survives FIFO underrun so a packet resumes where it stopped.
    always_ff @(posedge ACLK) begin
        if (RST) begin
            beat <= '0;
        end else if (pop) begin
            beat <= (beat == BEAT_LAST) ? '0 : beat + BEAT_W'(1);
        end
    end

    assign M_AXIS_TLAST = M_AXIS_TVALID && (beat == BEAT_LAST);
`else
    assign M_AXIS_TLAST = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_to_axis.sv
// Directed bench for fifo_to_axis: cycle table for first-word timing, then stall, random, and reset sequences.
module tb_fifo_to_axis;

    localparam int unsigned W       = 32;
    localparam int unsigned PKT     = 4;
    localparam int unsigned SRC_MAX = 1024;
`ifdef FIFO_TO_AXIS_TLAST_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    logic         ACLK = 1'b0;
    logic         RST = 1'b1;
    logic         FIFO_RD_ENA;
    logic [W-1:0] FIFO_RD_DATA = '0;
    logic         FIFO_RD_EMPTY;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TREADY = 1'b0;
    logic [W-1:0] M_AXIS_TDATA;
    logic         M_AXIS_TLAST;

    fifo_to_axis #(.FIFO_WIDTH(W), .PKT_LEN(PKT)) dut (
        .ACLK          (ACLK),
        .RST           (RST),
        .FIFO_RD_ENA   (FIFO_RD_ENA),
        .FIFO_RD_DATA  (FIFO_RD_DATA),
        .FIFO_RD_EMPTY (FIFO_RD_EMPTY),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Source FIFO model: one-cycle read latency, cleared together with the DUT.
    logic [W-1:0] src [SRC_MAX];
    int           src_len = 0;
    int           rd_idx  = 0;
    logic         gap     = 1'b0;

    assign FIFO_RD_EMPTY = gap || (rd_idx >= src_len);

    always @(posedge ACLK) begin
        if (RST) begin
            rd_idx <= 0;
        end else if (FIFO_RD_ENA) begin
            FIFO_RD_DATA <= src[rd_idx];
            rd_idx       <= rd_idx + 1;
        end
    end

    // Stream monitor: order, TLAST position, AXIS hold rule and buffer credit.
    int           rx_idx   = 0;
    int           last_cnt = 0;
    int           ena_tot  = 0;
    int           pop_tot  = 0;
    logic         prev_rst = 1'b1;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;
    logic         exp_last;

    always @(negedge ACLK) begin
        if (RST) begin
            rx_idx   = 0;
            last_cnt = 0;
            ena_tot  = 0;
            pop_tot  = 0;
        end else begin
            if (!prev_rst && prev_valid && !prev_ready) begin
                chk("hold_valid", W'(M_AXIS_TVALID), W'(1));
                chk("hold_data", M_AXIS_TDATA, prev_data);
                chk("hold_last", W'(M_AXIS_TLAST), W'(prev_last));
            end
            chk("occupancy_le_3", W'((ena_tot - pop_tot) <= 3), W'(1));
            if (FIFO_RD_ENA) ena_tot++;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                exp_last = TLAST_EN && ((rx_idx % PKT) == (PKT - 1));
                chk("beat_data", M_AXIS_TDATA, src[rx_idx]);
                chk("beat_last", W'(M_AXIS_TLAST), W'(exp_last));
                if (M_AXIS_TLAST) last_cnt++;
                rx_idx++;
                pop_tot++;
            end
        end
        prev_rst   = RST;
        prev_valid = M_AXIS_TVALID;
        prev_ready = M_AXIS_TREADY;
        prev_data  = M_AXIS_TDATA;
        prev_last  = M_AXIS_TLAST;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic reset_and_load(input int n, input logic [W-1:0] base, input bit rnd, input logic rdy);
        RST           = 1'b1;
        M_AXIS_TREADY = rdy;
        gap           = 1'b0;
        for (int i = 0; i < n; i++) src[i] = rnd ? W'($urandom) : base + W'(i);
        src_len = n;
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_rx(input string name, input int n, input int budget);
        for (int c = 0; c < budget && rx_idx < n; c++) tick();
        chk(name, W'(rx_idx), W'(n));
    endtask

    typedef struct {
        logic         rst;
        logic         rdy;
        logic         ena;
        logic         valid;
        logic         use_data;
        logic [W-1:0] data;
        logic         last;
    } vec_t;

    vec_t tv [7];
    int   pulses;

    initial begin
        // Cycle-accurate start-up with 0x11,0x22,0x33 waiting in the FIFO.
        tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
        tv[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
        tv[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
        tv[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0};
        tv[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 1'b0};
        tv[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 1'b0};
        tv[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};

        src[0] = 32'h11;
        src[1] = 32'h22;
        src[2] = 32'h33;
        src_len = 3;
        tick();
        for (int i = 0; i < 7; i++) begin
            RST           = tv[i].rst;
            M_AXIS_TREADY = tv[i].rdy;
            @(negedge ACLK);
            chk($sformatf("tv%0d_ena", i), W'(FIFO_RD_ENA), W'(tv[i].ena));
            chk($sformatf("tv%0d_valid", i), W'(M_AXIS_TVALID), W'(tv[i].valid));
            chk($sformatf("tv%0d_last", i), W'(M_AXIS_TLAST), W'(tv[i].last));
            if (tv[i].use_data) chk($sformatf("tv%0d_data", i), M_AXIS_TDATA, tv[i].data);
            tick();
        end
        chk("startup_rx", W'(rx_idx), W'(3));

        // Ten words 0..9 then two more after an underrun; TLAST on stream indices 3, 7, 11.
        reset_and_load(10, 32'h0, 1'b0, 1'b1);
        wait_rx("pkt_rx10", 10, 100);
        src[10] = 32'd10;
        src[11] = 32'd11;
        src_len = 12;
        wait_rx("pkt_rx12", 12, 100);
        chk("pkt_last_count", W'(last_cnt), TLAST_EN ? W'(3) : W'(0));

        // Stalled sink: exactly three reads, first word held steady.
        reset_and_load(10, 32'h100, 1'b0, 1'b0);
        pulses = 0;
        repeat (8) begin
            @(negedge ACLK);
            if (FIFO_RD_ENA) pulses++;
        end
        chk("stall_pulses", W'(pulses), W'(3));
        chk("stall_ena_off", W'(FIFO_RD_ENA), W'(0));
        chk("stall_valid", W'(M_AXIS_TVALID), W'(1));
        chk("stall_data", M_AXIS_TDATA, 32'h100);
        tick();
        M_AXIS_TREADY = 1'b1;
        wait_rx("stall_rx", 10, 100);

        // Random ready and FIFO gaps over 1000 words.
        reset_and_load(1000, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 30000 && rx_idx < 1000; c++) begin
            M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
            gap           = ($urandom_range(0, 4) == 0);
            tick();
        end
        M_AXIS_TREADY = 1'b1;
        gap           = 1'b0;
        chk("random_rx", W'(rx_idx), W'(1000));

        // Reset with two words buffered and one in flight.
        reset_and_load(10, 32'h200, 1'b0, 1'b0);
        repeat (3) tick();
        chk("pre_rst_cnt", W'(dut.cnt), W'(2));
        chk("pre_rst_pending", W'(dut.pending), W'(1));
        RST           = 1'b1;
        M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 6; i++) src[i] = 32'h300 + W'(i);
        src_len = 6;
        tick();
        RST = 1'b0;
        @(negedge ACLK);
        chk("post_rst_valid", W'(M_AXIS_TVALID), W'(0));
        chk("post_rst_cnt", W'(dut.cnt), W'(0));
        chk("post_rst_ena", W'(FIFO_RD_ENA), W'(1));
        tick();
        wait_rx("post_rst_rx", 6, 100);
        chk("post_rst_last_count", W'(last_cnt), TLAST_EN ? W'(1) : W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
